wb_stream_dma: RTL and testbench

WB_STREAM_DMA -- requirements
Module: wb_stream_dma

---
 rtl/wb_stream_dma.sv | 178 +++++++++++++++++
 tb/tb_wb_stream_dma.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_dma.sv
// rtl/wb_stream_dma.sv - Wishbone initiator moving stream samples through a memory-mapped bridge
//
// Each sample X[n] taken from the input stream is written to pX_ADDR, the
// result Y[n] is read back from pY_ADDR and offered on the output stream.
// Every output is a register.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, len          one-cycle job start; sample count captured at start
//   busy                job in progress
//   done                one-cycle completion pulse
//   error               sticky bus timeout flag, cleared by the next accepted start
//   s_tvalid/s_tready/s_tdata            input sample stream X[n]
//   m_tvalid/m_tready/m_tdata/m_tlast    output sample stream Y[n]
//   wbm_cyc_o .. wbm_ack_i               Wishbone master port
module wb_stream_dma #(
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned pLEN_WIDTH  = 10,
   parameter int unsigned pTIMEOUT    = 255,
   parameter logic [31:0] pX_ADDR     = 32'h30000080,
   parameter logic [31:0] pY_ADDR     = 32'h30000084
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [pLEN_WIDTH-1:0]  len,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [pDATA_WIDTH-1:0] s_tdata,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [pDATA_WIDTH-1:0] m_tdata,
   output logic                   m_tlast,
   output logic                   wbm_cyc_o,
   output logic                   wbm_stb_o,
   output logic                   wbm_we_o,
   output logic [3:0]             wbm_sel_o,
   output logic [31:0]            wbm_adr_o,
   output logic [pDATA_WIDTH-1:0] wbm_dat_o,
   input  logic [pDATA_WIDTH-1:0] wbm_dat_i,
   input  logic                   wbm_ack_i
);

   localparam int unsigned WAIT_W = $clog2(pTIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, GET_X, WR, GAP1, RD, GAP2, PUT_Y, DONE, ERR
   } state_t;

   state_t                  state_q, state_d;
   logic [pLEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic [WAIT_W-1:0]       wait_q, wait_d, wait_inc;
   logic                    error_q, error_d;
   logic [pDATA_WIDTH-1:0]  x_q, x_d;
   logic [pDATA_WIDTH-1:0]  y_q, y_d;
   logic                    busy_q, done_q, s_tready_q, m_tvalid_q, m_tlast_q;
   logic                    cyc_q, stb_q, we_q;
   logic [3:0]              sel_q;
   logic [31:0]             adr_q;

   assign wait_inc = wait_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wait_d  = '0;
      error_d = error_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = len;
               error_d = 1'b0;
               state_d = (len == '0) ? DONE : GET_X;
            end
         end
         GET_X: begin
            if (s_tvalid && s_tready_q) begin
               x_d     = s_tdata;
               state_d = WR;
            end
         end
         WR: begin
            if (wbm_ack_i) begin
               state_d = GAP1;
            end else if (wait_inc == WAIT_W'(pTIMEOUT)) begin
               // pTIMEOUT cycles without ack: abandon the access.
               error_d = 1'b1;
               state_d = ERR;
            end else begin
               wait_d = wait_inc;
            end
         end
         GAP1: state_d = RD;
         RD: begin
            if (wbm_ack_i) begin
               y_d     = wbm_dat_i;
               state_d = GAP2;
            end else if (wait_inc == WAIT_W'(pTIMEOUT)) begin
               error_d = 1'b1;
               state_d = ERR;
            end else begin
               wait_d = wait_inc;
            end
         end
         GAP2: state_d = PUT_Y;
         PUT_Y: begin
            if (m_tvalid_q && m_tready) begin
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == pLEN_WIDTH'(1)) ? DONE : GET_X;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wait_q     <= '0;
         error_q    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s_tready_q <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         sel_q      <= 4'h0;
         adr_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         error_q    <= error_d;
         x_q        <= x_d;
         y_q        <= y_d;
         busy_q     <= state_d inside {GET_X, WR, GAP1, RD, GAP2, PUT_Y};
         done_q     <= (state_d == DONE);
         s_tready_q <= (state_d == GET_X);
         m_tvalid_q <= (state_d == PUT_Y);
         m_tlast_q  <= (state_d == PUT_Y) && (cnt_d == pLEN_WIDTH'(1));
         cyc_q      <= (state_d == WR) || (state_d == RD);
         stb_q      <= (state_d == WR) || (state_d == RD);
         we_q       <= (state_d == WR);
         sel_q      <= ((state_d == WR) || (state_d == RD)) ? 4'hF : 4'h0;
         adr_q      <= (state_d == WR) ? pX_ADDR :
                       (state_d == RD) ? pY_ADDR : 32'h0;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign s_tready  = s_tready_q;
   assign m_tvalid  = m_tvalid_q;
   assign m_tdata   = y_q;
   assign m_tlast   = m_tlast_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = x_q;

endmodule

// File: tb/tb_wb_stream_dma.sv
// tb/tb_wb_stream_dma.sv - scoreboard bench for wb_stream_dma with a Wishbone responder model
module tb_wb_stream_dma;

   localparam int DW = 32;
   localparam int LW = 10;
   localparam logic [31:0] XA = 32'h30000080;
   localparam logic [31:0] YA = 32'h30000084;

   logic clk = 1'b0;
   logic rst, start;
   logic [LW-1:0] len;
   logic busy, done, error;
   logic s_tvalid, s_tready;
   logic [DW-1:0] s_tdata;
   logic m_tvalid, m_tready, m_tlast;
   logic [DW-1:0] m_tdata;
   logic wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [3:0] wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [DW-1:0] wbm_dat_o, wbm_dat_i;

   always #5 clk = ~clk;

   wb_stream_dma #(.pTIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .busy(busy), .done(done), .error(error),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] src_q[$];
   logic [DW:0]   sb_q[$];

   int wait_cfg = 0;
   bit no_ack_rd = 1'b0;
   int wcnt = 0, last_acc = 0, wr_cnt = 0, rd_cnt = 0;
   logic [DW-1:0] stored = '0, held_dat = '0;
   logic [31:0] held_adr = '0;
   logic held_we = 1'b0;

   int stall_idx = -1, sink_idx = 0, stall_cnt = 0;
   bit stalled = 1'b0;
   logic [DW-1:0] stall_dat = '0;
   logic stall_last = 1'b0;

   int n_done = 0, n_cyc = 0, n_strm = 0;
   logic err_at1 = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // One clock: monitors, Wishbone responder, stream source and sink all run
   // at the falling edge so DUT outputs are stable and inputs settle before
   // the next rising edge.
   task automatic step();
      logic [DW:0] e;
      @(negedge clk);
      if (done) n_done++;
      if (wbm_cyc_o) n_cyc++;
      if (s_tready || m_tvalid) n_strm++;

      if (wbm_cyc_o && wbm_stb_o) begin
         if (wcnt == 0) begin
            held_adr = wbm_adr_o;
            held_we  = wbm_we_o;
            held_dat = wbm_dat_o;
         end else begin
            chk("wb_adr_hold", wbm_adr_o, held_adr);
            chk("wb_we_hold", 32'(wbm_we_o), 32'(held_we));
            if (held_we) chk("wb_dat_hold", wbm_dat_o, held_dat);
         end
         if (wcnt >= wait_cfg && !(no_ack_rd && !wbm_we_o)) begin
            wbm_ack_i = 1'b1;
            chk("wb_sel", 32'(wbm_sel_o), 32'hF);
            if (wbm_we_o) begin
               chk("wb_wr_adr", wbm_adr_o, XA);
               stored = wbm_dat_o;
               wr_cnt++;
            end else begin
               chk("wb_rd_adr", wbm_adr_o, YA);
               wbm_dat_i = stored + 32'd100;
               rd_cnt++;
            end
         end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
         end
         wcnt++;
      end else begin
         wbm_ack_i = 1'b0;
         wbm_dat_i = $urandom;
         if (wcnt != 0) last_acc = wcnt;
         wcnt = 0;
      end

      if (src_q.size() > 0) begin
         s_tvalid = 1'b1;
         s_tdata  = src_q[0];
         if (s_tready) begin
            sb_q.push_back({src_q.size() == 1, src_q[0] + 32'd100});
            void'(src_q.pop_front());
         end
      end else begin
         s_tvalid = 1'b0;
      end

      if (m_tvalid) begin
         if (stalled) begin
            chk("m_tdata_hold", m_tdata, stall_dat);
            chk("m_tlast_hold", 32'(m_tlast), 32'(stall_last));
         end
         if (sink_idx == stall_idx && stall_cnt < 4) begin
            m_tready   = 1'b0;
            stall_cnt++;
            stalled    = 1'b1;
            stall_dat  = m_tdata;
            stall_last = m_tlast;
         end else begin
            m_tready = 1'b1;
            stalled  = 1'b0;
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 32'(sb_q.size()), 1);
            end else begin
               e = sb_q.pop_front();
               chk("m_tdata", m_tdata, e[DW-1:0]);
               chk("m_tlast", 32'(m_tlast), 32'(e[DW]));
            end
            sink_idx++;
         end
      end else begin
         m_tready = 1'b1;
      end
   endtask

   task automatic flush();
      src_q.delete();
      sb_q.delete();
      s_tvalid = 1'b0;
   endtask

   task automatic run_job(input int n, input bit poke, output int lat, output bit got_err);
      sink_idx = 0;
      stall_cnt = 0;
      stalled = 1'b0;
      lat = 0;
      got_err = 1'b0;
      start = 1'b1;
      len = LW'(n);
      for (int k = 1; k <= 500; k++) begin
         step();
         if (k == 1) err_at1 = error;
         start = poke && (k == 4 || k == 9);
         if (poke) len = LW'(7);
         if (done) begin
            lat = k;
            break;
         end
         if (error) begin
            lat = k;
            got_err = 1'b1;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctl"}, 32'({busy, done, error, s_tready, m_tvalid, m_tlast,
                              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'h0);
      chk({tag, "_adr"}, wbm_adr_o, 32'h0);
      chk({tag, "_dat_o"}, wbm_dat_o, 32'h0);
      chk({tag, "_m_tdata"}, m_tdata, 32'h0);
   endtask

   initial begin
      int lat, d0, w0, r0, c0, s0;
      bit ge;
      rst = 1'b1; start = 1'b0; len = '0;
      s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
      wbm_dat_i = '0; wbm_ack_i = 1'b0;
      step(); step();
      chk_reset_outs("reset");
      rst = 1'b0;
      step();

      // len=3, zero-wait responder, free-flowing streams
      src_q.push_back(32'd1); src_q.push_back(32'd2); src_q.push_back(32'd3);
      d0 = n_done; w0 = wr_cnt; r0 = rd_cnt;
      run_job(3, 1'b0, lat, ge);
      chk("a_latency", lat, 19);
      chk("a_got_err", 32'(ge), 0);
      step(); step();
      chk("a_done_cnt", n_done - d0, 1);
      chk("a_writes", wr_cnt - w0, 3);
      chk("a_reads", rd_cnt - r0, 3);
      chk("a_sb_empty", 32'(sb_q.size()), 0);
      chk("a_error", 32'(error), 0);
      chk("a_busy", 32'(busy), 0);

      // len=0: immediate done, no bus or stream activity
      d0 = n_done; c0 = n_cyc; s0 = n_strm;
      run_job(0, 1'b0, lat, ge);
      chk("b_latency", lat, 1);
      step(); step(); step();
      chk("b_done_cnt", n_done - d0, 1);
      chk("b_no_cyc", n_cyc - c0, 0);
      chk("b_no_stream", n_strm - s0, 0);

      // 5 wait states per access, output stalled 4 cycles on sample 2
      wait_cfg = 5; stall_idx = 1;
      for (int i = 0; i < 3; i++) src_q.push_back($urandom);
      d0 = n_done; w0 = wr_cnt; r0 = rd_cnt;
      run_job(3, 1'b0, lat, ge);
      chk("c_latency", lat, 53);
      step();
      chk("c_done_cnt", n_done - d0, 1);
      chk("c_writes", wr_cnt - w0, 3);
      chk("c_reads", rd_cnt - r0, 3);
      chk("c_sb_empty", 32'(sb_q.size()), 0);
      chk("c_stalls", stall_cnt, 4);
      wait_cfg = 0; stall_idx = -1;

      // read never acknowledged: timeout after 8 wait cycles
      no_ack_rd = 1'b1;
      src_q.push_back(32'd7); src_q.push_back(32'd8);
      d0 = n_done;
      run_job(2, 1'b0, lat, ge);
      chk("d_got_err", 32'(ge), 1);
      chk("d_latency", lat, 12);
      chk("d_busy", 32'(busy), 0);
      chk("d_cyc", 32'(wbm_cyc_o), 0);
      chk("d_rd_waits", last_acc, 8);
      step(); step(); step();
      chk("d_error_sticky", 32'(error), 1);
      chk("d_no_done", n_done - d0, 0);
      no_ack_rd = 1'b0;
      flush();
      step();

      src_q.push_back(32'd9);
      d0 = n_done;
      run_job(1, 1'b0, lat, ge);
      chk("d2_err_cleared", 32'(err_at1), 0);
      chk("d2_latency", lat, 7);
      chk("d2_got_err", 32'(ge), 0);
      chk("d2_done_cnt", n_done - d0, 1);
      step();

      // reset during the write of sample 2
      wait_cfg = 3;
      src_q.push_back(32'h55); src_q.push_back(32'h66); src_q.push_back(32'h77);
      sink_idx = 0; stall_cnt = 0; stalled = 1'b0;
      d0 = n_done; w0 = wr_cnt;
      start = 1'b1; len = LW'(3);
      step();
      start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (wbm_cyc_o && wbm_we_o && wcnt == 1 && wr_cnt - w0 == 1) break;
         step();
      end
      chk("e_in_wr2", 32'(wbm_cyc_o && wbm_we_o && wcnt == 1 && wr_cnt - w0 == 1), 1);
      rst = 1'b1;
      step();
      chk_reset_outs("e_rst");
      rst = 1'b0;
      flush();
      wait_cfg = 0;
      for (int i = 0; i < 5; i++) step();
      chk("e_no_done", n_done - d0, 0);
      chk("e_one_write", wr_cnt - w0, 1);
      chk("e_idle_cyc", 32'(wbm_cyc_o), 0);
      src_q.push_back(32'd5);
      d0 = n_done;
      run_job(1, 1'b0, lat, ge);
      chk("e2_latency", lat, 7);
      chk("e2_done_cnt", n_done - d0, 1);
      chk("e2_error", 32'(error), 0);
      step();

      // start pulses while busy are ignored
      src_q.push_back(32'd10); src_q.push_back(32'd20); src_q.push_back(32'd30);
      d0 = n_done; w0 = wr_cnt;
      run_job(3, 1'b1, lat, ge);
      chk("f_latency", lat, 19);
      for (int i = 0; i < 10; i++) step();
      chk("f_done_cnt", n_done - d0, 1);
      chk("f_writes", wr_cnt - w0, 3);
      chk("f_sb_empty", 32'(sb_q.size()), 0);
      chk("f_busy", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
